// File: rtl/pattern_pkg.sv
// pattern_pkg: shared definitions for the even/odd counting pattern generator and checker
package pattern_pkg;
  typedef enum logic [1:0] {ACQ, SYNC, EVEN, ODD} state_t;
  localparam int STEP = 2;
  localparam int FIRST_ODD = 1;
  localparam int DEF_W = 4;
endpackage

// File: rtl/pattern_predict.sv
// pattern_predict: next-value rule of the pattern stream
// Ports: mode (1 = even, 0 = odd), last (previous sample),
//        expected (last + STEP), zero_only (odd stream at its top value, only 0 may follow)
module pattern_predict import pattern_pkg::*; #(
  parameter int W = DEF_W
) (
  input  logic         mode,
  input  logic [W-1:0] last,
  output logic [W-1:0] expected,
  output logic         zero_only
);
  assign expected = last + W'(STEP);
  assign zero_only = !mode && &last;
endmodule

// File: rtl/pattern_chk.sv
// pattern_chk: receive-side checker that locks onto the even/odd pattern stream and counts violations
// Ports: clk, rst (async, active high), en (sample valid), y (sample), clr (clears err_cnt),
//        mode (1 = even), locked, err (violation pulse), mode_chg (mode switch pulse), err_cnt (saturating)
module pattern_chk import pattern_pkg::*; #(
  parameter int W = DEF_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [W-1:0]     y,
  input  logic             clr,
  output logic             mode,
  output logic             locked,
  output logic             err,
  output logic             mode_chg,
  output logic [CNT_W-1:0] err_cnt
);
  state_t state, st_n;
  logic [W-1:0] last, expected;
  logic zero_only, md_n, lk_n, err_n, chg_n;
  pattern_predict #(.W(W)) u_predict (
    .mode(mode),
    .last(last),
    .expected(expected),
    .zero_only(zero_only)
  );
  always_comb begin
    st_n = state;
    md_n = mode;
    lk_n = locked;
    err_n = 1'b0;
    chg_n = 1'b0;
    if (en) begin
      if (state == SYNC) begin
        if (y == W'(STEP) || y == W'(FIRST_ODD)) begin
          md_n = y == W'(STEP);
          st_n = md_n ? EVEN : ODD;
          chg_n = locked && md_n != mode;
          lk_n = 1'b1;
        end else begin
          // a repeated 0 keeps waiting for the deciding sample, anything else loses the stream
          err_n = 1'b1;
          lk_n = 1'b0;
          st_n = y == '0 ? SYNC : ACQ;
        end
      end else if (y == '0) begin
        st_n = SYNC;
      end else if (state != ACQ && (zero_only || y != expected)) begin
        err_n = 1'b1;
        lk_n = 1'b0;
        st_n = ACQ;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACQ;
      last <= '0;
      mode <= 1'b0;
      locked <= 1'b0;
      err <= 1'b0;
      mode_chg <= 1'b0;
      err_cnt <= '0;
    end else begin
      state <= st_n;
      mode <= md_n;
      locked <= lk_n;
      err <= err_n;
      mode_chg <= chg_n;
      if (en) last <= y;
      err_cnt <= clr ? '0 : (err_n && !(&err_cnt)) ? err_cnt + CNT_W'(1) : err_cnt;
    end
  end
endmodule

// File: doc/pattern_chk.md
Name: pattern_chk

Overview:
- Receive-side checker for the 4-bit even/odd counting pattern stream driven by the team's pattern generator.
- Samples the stream on enabled cycles and recovers the generator mode (1 = even, 0 = odd).
- Tracks lock, flags sequence violations and counts errors.
- Sits at the far end of the pattern link, typically in loopback benches or on-board self-test.

Parameters:
- W, 4, pattern data width; all arithmetic is modulo 2^W.
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  sample valid; y is ignored (may be X) when low.
- y  input  W  pattern sample.
- clr  input  1  synchronous clear of err_cnt; ignores en.
- mode  output  1  recovered mode: 1 = even (0,2,..,2^W-2,0,..), 0 = odd (0,1,3,..,2^W-1,0,..).
- locked  output  1  stream is being tracked with no error since last acquisition.
- err  output  1  one-cycle pulse on a sequence violation.
- mode_chg  output  1  one-cycle pulse when a locked stream switches mode.
- err_cnt  output  CNT_W  saturating count of err pulses.

Behaviour:
- All outputs are registered. Every response appears on the clock edge after the sampled cycle (latency 1).
- Reset: state ACQ, mode=0, locked=0, err=0, mode_chg=0, err_cnt=0, last-sample register=0.
- en=0: state, last sample, mode and locked hold; err and mode_chg are 0; y is not evaluated.
- States: ACQ (unlocked, searching), SYNC (0 seen, mode undecided), EVEN, ODD.
- Global rule: an enabled sample y==0 in ACQ, EVEN or ODD moves to SYNC with no error. The generator emits 0 on wrap and on every mode switch.
- ACQ: nonzero samples are ignored, with no err and no count.
- SYNC, deciding sample:
  - y==2 -> EVEN.
  - y==1 -> ODD.
  - y==0 -> err, stay in SYNC.
  - any other value -> err, locked=0, go to ACQ.
- On a decision: if locked was 1 and the new mode differs from mode, pulse mode_chg. Then set mode and set locked=1.
- locked is held through SYNC; it is cleared only by err or rst.
- EVEN: expected value = last+2 (mod 2^W). A nonzero mismatch -> err, locked=0, go to ACQ.
- ODD: expected value = last+2, except that after last == 2^W-1 only 0 is legal. Any nonzero sample after 2^W-1 -> err, go to ACQ.
- err_cnt:
  - Increments by 1 on each err and saturates at 2^CNT_W-1.
  - clr has priority; if clr and err occur in the same cycle, the result is 0.
- A simultaneous err and decision cannot occur, because SYNC produces exactly one outcome per sample.
- Reset asserted mid-stream returns every output to its reset value immediately (asynchronous). Re-acquisition then requires a fresh 0.

Decomposition:
- Shared package pattern_pkg holds:
  - state encoding (ACQ, SYNC, EVEN, ODD);
  - STEP=2;
  - first-odd constant 1;
  - the default W.
- The generator also uses pattern_pkg.
- One combinational sub-module, pattern_predict, takes (mode, last) and returns (expected value, zero_only flag). This keeps the next-value rule in one place.

Test Plan:
1. Apply rst mid-stream while locked with err_cnt=5 -> all outputs are 0 immediately. Then drive 0,2 -> locked=1 and mode=1 one cycle after the 2.
2. Even stream 0,2,..,14,0,2,.. for 40 enabled samples -> mode=1; locked rises after the first 2 and stays 1; err never asserts; err_cnt=0.
3. Odd stream 0,1,3,..,15,0,1,.. for 40 samples -> mode=0, locked=1, err=0 throughout.
4. Mode switch: even 0,2,4,6 then 0,1,3 -> one mode_chg pulse one cycle after the sample 1; mode=0; err=0; locked stays 1.
5. Corruption: 0,2,4,7,9,11,0,2 -> err pulses once, after the 7; err_cnt=1; locked=0 through 9 and 11 with no further err; locked=1 again after the final 2.
6. Gaps and saturation (CNT_W=2):
   - An even stream with en low for 3 cycles while y=X -> no err; tracking resumes at the next value.
   - Then 5 injected errors -> err_cnt stays 3.
   - Then assert clr -> err_cnt=0 on the next edge.
